// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Fetch-stage controller for the instruction-memory read port. Owns the
//   program counter, keeps at most one read in flight, and buffers returned
//   words together with their address in a small FIFO for decode. Handles
//   branch redirects (including discarding an in-flight read) and halt.
//
// Ports
//   clock           in   rising-edge clock
//   reset           in   asynchronous, active-high reset
//   halt_in         in   level; blocks issue of new reads
//   redirect_valid  in   1-cycle pulse: flush and refetch from redirect_pc
//   redirect_pc     in   branch target, valid with redirect_valid
//   mem_req         out  read request (registered)
//   mem_addr        out  read address (registered), stable while mem_req=1
//   mem_ack         in   read complete this cycle; ignored when mem_req=0
//   mem_rdata       in   read data, valid with mem_ack
//   inst_valid      out  FIFO head is valid
//   inst_data       out  FIFO head instruction word
//   inst_pc         out  address of inst_data
//   inst_ready      in   decode accepts the head this cycle
//   fetch_pc        out  next address to be requested
//   halted          out  halt_in=1 and no read outstanding
module fetch_sequencer #(
  parameter int                  PC_WIDTH   = 20,
  parameter int                  DATA_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
  parameter int                  BUF_DEPTH  = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  halt_in,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic                  mem_req,
  output logic [PC_WIDTH-1:0]   mem_addr,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  inst_valid,
  output logic [DATA_WIDTH-1:0] inst_data,
  output logic [PC_WIDTH-1:0]   inst_pc,
  input  logic                  inst_ready,
  output logic [PC_WIDTH-1:0]   fetch_pc,
  output logic                  halted
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_DROP = 1'b1;

  logic [0:0]            state;
  logic [0:0]            state_next;
  logic [PC_WIDTH-1:0]   fetch_pc_next;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      count_next;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PC_WIDTH-1:0]   buf_pc   [BUF_DEPTH];
  logic [DATA_WIDTH-1:0] buf_data [BUF_DEPTH];

  logic ack;
  logic pop;
  logic push;
  logic outstanding_next;
  logic issue;

  assign inst_valid = (count != '0);
  assign inst_data  = buf_data[rd_ptr];
  assign inst_pc    = buf_pc[rd_ptr];
  assign halted     = halt_in & ~mem_req;

  // Edge ordering: flush/pop first, then push of ack data, then the issue
  // decision is made on the resulting occupancy. A redirect voids both the
  // pop and any push of the same edge. Issuing only while count_next is
  // below depth reserves a slot for the single outstanding read, so a push
  // can never find the FIFO full.
  always_comb begin
    ack              = mem_req & mem_ack;
    pop              = inst_valid & inst_ready & ~redirect_valid;
    push             = ack & (state == ST_RUN) & ~redirect_valid;
    outstanding_next = mem_req & ~mem_ack;

    fetch_pc_next = fetch_pc;
    if (redirect_valid)
      fetch_pc_next = redirect_pc;
    else if (push)
      fetch_pc_next = fetch_pc + PC_WIDTH'(1);

    state_next = state;
    if (state == ST_RUN) begin
      if (redirect_valid && outstanding_next)
        state_next = ST_DROP;
    end else begin
      if (ack)
        state_next = ST_RUN;
    end

    if (redirect_valid)
      count_next = '0;
    else
      count_next = count + CNT_W'(push) - CNT_W'(pop);

    issue = ~outstanding_next & (state_next == ST_RUN) & ~halt_in &
            (count_next < CNT_W'(BUF_DEPTH));
  end

  // Control registers: PC, state, and the request port. The request is held
  // unchanged until acked; an abandoned read stays on the port in DROP.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_RUN;
      fetch_pc <= RESET_PC;
      mem_req  <= 1'b0;
      mem_addr <= RESET_PC;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      if (outstanding_next) begin
        mem_req <= 1'b1;
      end else if (issue) begin
        mem_req  <= 1'b1;
        mem_addr <= fetch_pc_next;
      end else begin
        mem_req <= 1'b0;
      end
    end
  end

  // Instruction FIFO: a flush simply rewinds both pointers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_pc[i]   <= '0;
        buf_data[i] <= '0;
      end
    end else begin
      count <= count_next;
      if (redirect_valid) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (pop)
          rd_ptr <= rd_ptr + PTR_W'(1);
        if (push) begin
          buf_pc[wr_ptr]   <= mem_addr;
          buf_data[wr_ptr] <= mem_rdata;
          wr_ptr           <= wr_ptr + PTR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
//   Directed bench for fetch_sequencer. The bench acts as instruction memory
//   (data is a fixed function of the address) and keeps a queue of the
//   {pc, data} pairs decode should see, in order.
module tb_fetch_sequencer;

  localparam int PW = 20;
  localparam int DW = 16;

  logic          clock;
  logic          reset;
  logic          halt_in;
  logic          redirect_valid;
  logic [PW-1:0] redirect_pc;
  logic          mem_req;
  logic [PW-1:0] mem_addr;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          inst_valid;
  logic [DW-1:0] inst_data;
  logic [PW-1:0] inst_pc;
  logic          inst_ready;
  logic [PW-1:0] fetch_pc;
  logic          halted;

  int checks   = 0;
  int failures = 0;

  logic [PW+DW-1:0] sbq[$];

  fetch_sequencer #(
    .PC_WIDTH   (PW),
    .DATA_WIDTH (DW),
    .RESET_PC   ('0),
    .BUF_DEPTH  (2)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .halt_in        (halt_in),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .inst_valid     (inst_valid),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .fetch_pc       (fetch_pc),
    .halted         (halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [DW-1:0] data_for(input logic [PW-1:0] a);
    return a[15:0] ^ 16'hA5C3 ^ {12'h000, a[19:16]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive inputs, check what decode sees this cycle against
  // the queue, record kept memory data, then advance to 1 time unit past
  // the next rising edge.
  task automatic applyStimulus(input logic ack, input logic ready,
                               input logic halt, input logic redir,
                               input logic [PW-1:0] rpc,
                               input logic [PW-1:0] exp_addr,
                               input logic keep);
    logic [PW+DW-1:0] head;
    halt_in        = halt;
    redirect_valid = redir;
    redirect_pc    = rpc;
    mem_ack        = ack;
    inst_ready     = ready;
    mem_rdata      = ack ? data_for(exp_addr) : '0;
    if (ack) begin
      checkOutput("ack_req", 32'(mem_req), 32'd1);
      checkOutput("ack_addr", 32'(mem_addr), 32'(exp_addr));
    end
    if (redir) begin
      sbq.delete();
    end else if (ready) begin
      if (sbq.size() > 0) begin
        head = sbq.pop_front();
        checkOutput("head_valid", 32'(inst_valid), 32'd1);
        checkOutput("head_pc", 32'(inst_pc), 32'(head[PW+DW-1:DW]));
        checkOutput("head_data", 32'(inst_data), 32'(head[DW-1:0]));
      end else begin
        checkOutput("empty_valid", 32'(inst_valid), 32'd0);
      end
    end
    if (ack && keep)
      sbq.push_back({exp_addr, data_for(exp_addr)});
    @(posedge clock);
    #1;
    redirect_valid = 1'b0;
    mem_ack        = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    halt_in        = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    mem_ack        = 1'b0;
    mem_rdata      = '0;
    inst_ready     = 1'b0;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    checkOutput("rst_req", 32'(mem_req), 32'd0);
    checkOutput("rst_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_fpc", 32'(fetch_pc), 32'd0);
    checkOutput("rst_valid", 32'(inst_valid), 32'd0);
    checkOutput("rst_data", 32'(inst_data), 32'd0);
    checkOutput("rst_ipc", 32'(inst_pc), 32'd0);
    checkOutput("rst_halted", 32'(halted), 32'd1);
    halt_in = 1'b0;
    reset   = 1'b0;

    // First request after reset release
    applyStimulus(0, 1, 0, 0, '0, '0, 0);
    checkOutput("first_req", 32'(mem_req), 32'd1);
    checkOutput("first_addr", 32'(mem_addr), 32'd0);

    $display("[TB] streaming, one word per cycle");
    for (int a = 0; a < 4; a++) begin
      applyStimulus(1, 1, 0, 0, '0, PW'(a), 1);
      checkOutput("stream_addr", 32'(mem_addr), 32'(a + 1));
    end
    applyStimulus(0, 1, 0, 0, '0, '0, 0);

    $display("[TB] back-pressure fills the buffer");
    applyStimulus(1, 0, 0, 0, '0, 20'h00004, 1);
    applyStimulus(1, 0, 0, 0, '0, 20'h00005, 1);
    checkOutput("full_req", 32'(mem_req), 32'd0);
    checkOutput("full_fpc", 32'(fetch_pc), 32'h6);
    checkOutput("full_ipc", 32'(inst_pc), 32'h4);
    applyStimulus(0, 0, 0, 0, '0, '0, 0);
    checkOutput("full_hold", 32'(mem_req), 32'd0);
    applyStimulus(0, 1, 0, 0, '0, '0, 0);
    checkOutput("resume_req", 32'(mem_req), 32'd1);
    checkOutput("resume_addr", 32'(mem_addr), 32'h6);
    applyStimulus(1, 1, 0, 0, '0, 20'h00006, 1);

    $display("[TB] redirect with read outstanding");
    applyStimulus(0, 1, 0, 1, 20'h00100, '0, 0);
    checkOutput("drop_valid", 32'(inst_valid), 32'd0);
    checkOutput("drop_req", 32'(mem_req), 32'd1);
    checkOutput("drop_addr", 32'(mem_addr), 32'h7);
    checkOutput("drop_fpc", 32'(fetch_pc), 32'h100);
    applyStimulus(0, 1, 0, 0, '0, '0, 0);
    applyStimulus(0, 1, 0, 0, '0, '0, 0);
    applyStimulus(1, 1, 0, 0, '0, 20'h00007, 0);
    checkOutput("drop_new_addr", 32'(mem_addr), 32'h100);
    checkOutput("drop_new_valid", 32'(inst_valid), 32'd0);

    $display("[TB] redirect coincident with ack");
    applyStimulus(1, 1, 0, 0, '0, 20'h00100, 1);
    applyStimulus(1, 1, 0, 1, 20'h00040, 20'h00101, 0);
    checkOutput("redir_ack_req", 32'(mem_req), 32'd1);
    checkOutput("redir_ack_addr", 32'(mem_addr), 32'h40);
    checkOutput("redir_ack_valid", 32'(inst_valid), 32'd0);
    checkOutput("redir_ack_fpc", 32'(fetch_pc), 32'h40);

    $display("[TB] halt with read outstanding");
    applyStimulus(0, 0, 1, 0, '0, '0, 0);
    checkOutput("halt_busy", 32'(halted), 32'd0);
    applyStimulus(1, 0, 1, 0, '0, 20'h00040, 1);
    checkOutput("halt_done", 32'(halted), 32'd1);
    checkOutput("halt_req", 32'(mem_req), 32'd0);
    checkOutput("halt_valid", 32'(inst_valid), 32'd1);
    applyStimulus(0, 1, 1, 0, '0, '0, 0);
    checkOutput("halt_noreq", 32'(mem_req), 32'd0);
    applyStimulus(0, 1, 0, 0, '0, '0, 0);
    checkOutput("unhalt_req", 32'(mem_req), 32'd1);
    checkOutput("unhalt_addr", 32'(mem_addr), 32'h41);
    checkOutput("unhalt_halted", 32'(halted), 32'd0);

    $display("[TB] PC wrap and asynchronous reset");
    applyStimulus(1, 1, 0, 1, 20'hFFFFF, 20'h00041, 0);
    checkOutput("wrap_top_addr", 32'(mem_addr), 32'hFFFFF);
    applyStimulus(1, 1, 0, 0, '0, 20'hFFFFF, 1);
    checkOutput("wrap_fpc", 32'(fetch_pc), 32'h0);
    checkOutput("wrap_addr", 32'(mem_addr), 32'h0);
    applyStimulus(1, 1, 0, 0, '0, 20'h00000, 1);
    checkOutput("pre_rst_req", 32'(mem_req), 32'd1);
    reset = 1'b1;
    #2;
    checkOutput("arst_req", 32'(mem_req), 32'd0);
    checkOutput("arst_valid", 32'(inst_valid), 32'd0);
    checkOutput("arst_fpc", 32'(fetch_pc), 32'd0);
    checkOutput("arst_addr", 32'(mem_addr), 32'd0);
    sbq.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
    applyStimulus(0, 1, 0, 0, '0, '0, 0);
    checkOutput("refetch_req", 32'(mem_req), 32'd1);
    checkOutput("refetch_addr", 32'(mem_addr), 32'd0);
    applyStimulus(1, 1, 0, 0, '0, 20'h00000, 1);
    applyStimulus(0, 1, 0, 0, '0, '0, 0);
    checkOutput("drained", 32'(sbq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
